// File: rtl/per2axi_res_scheduler.sv
// Response-side scheduler for the peripheral-to-AXI bridge: per-ID tracking of
// in-flight transactions and round-robin sharing of the peripheral response port.
module per2axi_res_scheduler #(
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ID_WIDTH   = 3,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              trans_req_i,
    input  logic                              trans_we_i,
    input  logic [AXI_ID_WIDTH-1:0]           trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]         trans_add_i,
    output logic                              trans_gnt_o,
    input  logic                              axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]         axi_master_r_data_i,
    input  logic [1:0]                        axi_master_r_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]           axi_master_r_id_i,
    output logic                              axi_master_r_ready_o,
    input  logic                              axi_master_b_valid_i,
    input  logic [1:0]                        axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]           axi_master_b_id_i,
    output logic                              axi_master_b_ready_o,
    output logic                              per_slave_r_valid_o,
    output logic                              per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]           per_slave_r_id_o,
    output logic [31:0]                       per_slave_r_rdata_o,
    output logic                              unexp_resp_o,
    output logic [$clog2(PER_ID_WIDTH+1)-1:0] outstanding_o,
    output logic                              busy_o
);

    localparam int unsigned CNT_W = $clog2(PER_ID_WIDTH + 1);

    logic [PER_ID_WIDTH-1:0] pend_q, we_q, a2_q;
    logic                    rr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    valid_q, opc_q, unexp_q;
    logic [PER_ID_WIDTH-1:0] id_q;
    logic [31:0]             rdata_q;

    logic                    r_ready, b_ready, hs, gnt, match, sel_a2;
    logic [AXI_ID_WIDTH-1:0] hs_id;
    logic [1:0]              hs_resp;
    logic [PER_ID_WIDTH-1:0] grant_vec, retire_vec;
    logic [31:0]             rdata_sel;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    unused_bits;

    // Round-robin arbitration, grant check and response matching against the table
    always_comb begin
        r_ready    = axi_master_r_valid_i && (!axi_master_b_valid_i || !rr_q);
        b_ready    = axi_master_b_valid_i && (!axi_master_r_valid_i || rr_q);
        hs         = r_ready || b_ready;
        hs_id      = b_ready ? axi_master_b_id_i : axi_master_r_id_i;
        hs_resp    = b_ready ? axi_master_b_resp_i : axi_master_r_resp_i;
        gnt        = 1'b0;
        grant_vec  = '0;
        retire_vec = '0;
        sel_a2     = 1'b0;
        for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
            if (trans_req_i && 32'(trans_id_i) == i && !pend_q[i]) begin
                gnt          = 1'b1;
                grant_vec[i] = 1'b1;
            end
            if (hs && 32'(hs_id) == i && pend_q[i] && (we_q[i] == b_ready)) begin
                retire_vec[i] = 1'b1;
            end
            if (32'(hs_id) == i) begin
                sel_a2 = a2_q[i];
            end
        end
        match     = |retire_vec;
        rdata_sel = b_ready ? 32'h0 :
                    (sel_a2 ? axi_master_r_data_i[63:32] : axi_master_r_data_i[31:0]);
        cnt_nxt   = cnt_q + CNT_W'(gnt) - CNT_W'(match);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= '0;
            we_q    <= '0;
            a2_q    <= '0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            opc_q   <= 1'b0;
            id_q    <= '0;
            rdata_q <= '0;
            unexp_q <= 1'b0;
        end else begin
            pend_q  <= (pend_q | grant_vec) & ~retire_vec;
            we_q    <= (we_q & ~grant_vec) | (grant_vec & {PER_ID_WIDTH{trans_we_i}});
            a2_q    <= (a2_q & ~grant_vec) | (grant_vec & {PER_ID_WIDTH{trans_add_i[2]}});
            if (hs) begin
                rr_q <= r_ready;
            end
            cnt_q   <= cnt_nxt;
            valid_q <= match;
            opc_q   <= match & hs_resp[1];
            id_q    <= retire_vec;
            rdata_q <= match ? rdata_sel : 32'h0;
            unexp_q <= hs && !match;
        end
    end

    assign trans_gnt_o          = gnt;
    assign axi_master_r_ready_o = r_ready;
    assign axi_master_b_ready_o = b_ready;
    assign per_slave_r_valid_o  = valid_q;
    assign per_slave_r_opc_o    = opc_q;
    assign per_slave_r_id_o     = id_q;
    assign per_slave_r_rdata_o  = rdata_q;
    assign unexp_resp_o         = unexp_q;
    assign outstanding_o        = cnt_q;
    assign busy_o               = (cnt_q != '0);

    // Only address bit 2 and the error bit of each response are meaningful here
    assign unused_bits = ^{trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0],
                           axi_master_r_resp_i[0], axi_master_b_resp_i[0]};

endmodule
